// File: rtl/silife_grid_dumper_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : silife_grid_dumper_if
// Purpose  : Host-side serial pin set for grid read-back (CS, serial clock,
//            host-to-device data, device-to-host data with output enable).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface silife_grid_dumper_if;
  logic i_dump_cs;
  logic i_dump_clk;
  logic i_dump_data;
  logic o_dump_data;
  logic o_dump_oe;

  modport slave (
    input  i_dump_cs,
    input  i_dump_clk,
    input  i_dump_data,
    output o_dump_data,
    output o_dump_oe
  );

  modport master (
    output i_dump_cs,
    output i_dump_clk,
    output i_dump_data,
    input  o_dump_data,
    input  o_dump_oe
  );
endinterface
`default_nettype wire

// File: rtl/silife_grid_dumper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : silife_grid_dumper
// Purpose  : Decodes a serial read command (segment + row address), fetches
//            rows from the grid row-read port and shifts cells out LSB first,
//            auto-advancing through rows until chip select is released.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module silife_grid_dumper #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic [14:0]         i_local_address,
  silife_grid_dumper_if.slave      dump,
  output logic      [ROW_BITS-1:0] o_row_select,
  input  wire logic [WIDTH-1:0]    i_row_cells
);

  // Counter must reach 15 for the row address and WIDTH-1 for the cells
  localparam int CNT_BITS = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

  localparam logic [CNT_BITS-1:0] c_seg_last  = CNT_BITS'(14);
  localparam logic [CNT_BITS-1:0] c_row_last  = CNT_BITS'(15);
  localparam logic [CNT_BITS-1:0] c_cell_last = CNT_BITS'(WIDTH - 1);

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_ignore     = 3'd1;
  localparam logic [2:0] c_st_seg_addr   = 3'd2;
  localparam logic [2:0] c_st_row_addr   = 3'd3;
  localparam logic [2:0] c_st_fetch_sel  = 3'd4;
  localparam logic [2:0] c_st_fetch_load = 3'd5;
  localparam logic [2:0] c_st_cell_data  = 3'd6;

  logic                r_cs_meta, r_cs_sync;
  logic                r_clk_meta, r_clk_sync, r_clk_prev;
  logic                r_data_meta, r_data_sync;
  logic [2:0]          r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [14:0]         r_seg;
  logic [15:0]         r_row;
  logic [WIDTH-1:0]    r_shreg;
  logic                r_dump_data;
  logic                w_rise, w_fall, w_selected;

  assign w_rise     = r_clk_sync & ~r_clk_prev;
  assign w_fall     = ~r_clk_sync & r_clk_prev;
  assign w_selected = (r_seg == i_local_address);

  assign dump.o_dump_data = r_dump_data;
  assign dump.o_dump_oe   = w_selected && (r_state == c_st_cell_data);

  // Two-flop synchronisers for the host pins plus a delayed clock for edge detect
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_clk_meta  <= 1'b0;
      r_clk_sync  <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_data_meta <= 1'b0;
      r_data_sync <= 1'b0;
    end else begin
      r_cs_meta   <= dump.i_dump_cs;
      r_cs_sync   <= r_cs_meta;
      r_clk_meta  <= dump.i_dump_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= dump.i_dump_data;
      r_data_sync <= r_data_meta;
    end
  end

  // Command decode, row fetch and cell shift-out; cs high aborts from any state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_seg        <= '0;
      r_row        <= '0;
      r_shreg      <= '0;
      r_dump_data  <= 1'b0;
      o_row_select <= '0;
    end else if (r_cs_sync) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_dump_data <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_rise) begin
            r_cnt <= '0;
            if (r_data_sync) begin
              r_state <= c_st_ignore;
            end else begin
              r_state <= c_st_seg_addr;
              r_seg   <= '0;
              r_row   <= '0;
            end
          end
        end
        c_st_seg_addr: begin
          // Shift in from the top so the first (LSB) bit lands at bit 0
          if (w_rise) begin
            r_seg <= {r_data_sync, r_seg[14:1]};
            if (r_cnt == c_seg_last) begin
              r_cnt   <= '0;
              r_state <= c_st_row_addr;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_st_row_addr: begin
          if (w_rise) begin
            r_row <= {r_data_sync, r_row[15:1]};
            if (r_cnt == c_row_last) begin
              r_cnt   <= '0;
              r_state <= c_st_fetch_sel;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_st_fetch_sel: begin
          o_row_select <= r_row[ROW_BITS-1:0];
          r_state      <= c_st_fetch_load;
        end
        c_st_fetch_load: begin
          // Grid output is valid one cycle after the select changed
          r_shreg <= i_row_cells;
          r_cnt   <= '0;
          r_state <= c_st_cell_data;
        end
        c_st_cell_data: begin
          if (w_fall) begin
            r_dump_data <= w_selected ? r_shreg[0] : 1'b0;
            r_shreg     <= r_shreg >> 1;
          end
          // The counter tracks bits the host has consumed, hence the rise
          if (w_rise) begin
            if (r_cnt == c_cell_last) begin
              r_cnt   <= '0;
              r_row   <= r_row + 16'd1;
              r_state <= c_st_fetch_sel;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          // c_st_ignore and unused encodings wait here for cs to rise
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_silife_grid_dumper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_silife_grid_dumper
// Purpose  : Directed self-checking bench for silife_grid_dumper.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_silife_grid_dumper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] local_address = 15'd5;
  logic [4:0]  row_select;
  logic [31:0] row_cells;
  logic [31:0] grid [32];

  int checks = 0;
  int errors = 0;

  silife_grid_dumper_if dump_if ();

  silife_grid_dumper #(.WIDTH(32), .HEIGHT(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_local_address (local_address),
    .dump            (dump_if),
    .o_row_select    (row_select),
    .i_row_cells     (row_cells)
  );

  always #5 clk = ~clk;

  assign row_cells = grid[row_select];

  // One host serial bit: set data, rise, hold high, fall; sample device data before the rise
  task automatic host_bit(input logic b, output logic q, output logic oe);
    dump_if.i_dump_data = b;
    #40;
    q  = dump_if.o_dump_data;
    oe = dump_if.o_dump_oe;
    dump_if.i_dump_clk = 1'b1;
    #80;
    dump_if.i_dump_clk = 1'b0;
    #40;
  endtask

  task automatic start_read(input logic [14:0] seg, input logic [15:0] row);
    logic q, oe;
    dump_if.i_dump_cs = 1'b0;
    #80;
    host_bit(1'b0, q, oe);
    for (int i = 0; i < 15; i++) host_bit(seg[i], q, oe);
    for (int i = 0; i < 16; i++) host_bit(row[i], q, oe);
  endtask

  task automatic end_xfer();
    dump_if.i_dump_cs = 1'b1;
    #80;
  endtask

  task automatic read_row(output logic [31:0] w, output int oe_n, output logic [4:0] sel);
    logic q, oe;
    oe_n = 0;
    w    = '0;
    sel  = '0;
    for (int k = 0; k < 32; k++) begin
      host_bit(1'b0, q, oe);
      w[k] = q;
      if (oe) oe_n++;
      if (k == 0) sel = row_select;
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    logic q, oe;
    reset_n = 1'b0;
    #30;
    checks++; if (dump_if.o_dump_data !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", dump_if.o_dump_data); end
    checks++; if (dump_if.o_dump_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", dump_if.o_dump_oe); end
    checks++; if (row_select !== 5'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", row_select); end
    reset_n = 1'b1;
    #20;
    // Mid-stream reset: three cells read, cell 3 (=1) is on the pin
    start_read(15'd5, 16'd3);
    for (int k = 0; k < 3; k++) host_bit(1'b0, q, oe);
    checks++; if (dump_if.o_dump_oe !== 1'b1 || dump_if.o_dump_data !== 1'b1) begin errors++; $display("FAIL pre_reset_stream got oe=%b data=%b want oe=1 data=1", dump_if.o_dump_oe, dump_if.o_dump_data); end
    reset_n = 1'b0;
    #20;
    checks++; if (dump_if.o_dump_data !== 1'b0 || dump_if.o_dump_oe !== 1'b0) begin errors++; $display("FAIL midreset_out got data=%b oe=%b want 0 0", dump_if.o_dump_data, dump_if.o_dump_oe); end
    checks++; if (row_select !== 5'd0) begin errors++; $display("FAIL midreset_sel got %0d want 0", row_select); end
    reset_n = 1'b1;
    end_xfer();
    w = '0;
  endtask

  task automatic test_single_row();
    logic [31:0] w;
    int oe_n;
    logic [4:0] sel;
    start_read(15'd5, 16'd3);
    read_row(w, oe_n, sel);
    checks++; if (w[7:0] !== 8'h0F) begin errors++; $display("FAIL single_first8 got %h want 0f", w[7:0]); end
    checks++; if (w !== 32'hA5A5_0F0F) begin errors++; $display("FAIL single_word got %h want a5a50f0f", w); end
    checks++; if (oe_n !== 32) begin errors++; $display("FAIL single_oe got %0d want 32", oe_n); end
    checks++; if (sel !== 5'd3) begin errors++; $display("FAIL single_sel got %0d want 3", sel); end
    end_xfer();
    checks++; if (dump_if.o_dump_oe !== 1'b0) begin errors++; $display("FAIL cs_high_oe got %b want 0", dump_if.o_dump_oe); end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    int oe_n;
    logic [4:0] sel;
    logic [4:0] exp_rows [3];
    exp_rows[0] = 5'd31; exp_rows[1] = 5'd0; exp_rows[2] = 5'd1;
    start_read(15'd5, 16'd31);
    for (int r = 0; r < 3; r++) begin
      read_row(w, oe_n, sel);
      checks++; if (sel !== exp_rows[r]) begin errors++; $display("FAIL wrap_sel%0d got %0d want %0d", r, sel, exp_rows[r]); end
      checks++; if (w !== grid[exp_rows[r]] || oe_n !== 32) begin errors++; $display("FAIL wrap_word%0d got %h oe=%0d want %h oe=32", r, w, oe_n, grid[exp_rows[r]]); end
    end
    end_xfer();
  endtask

  task automatic test_upper_row_bits();
    logic [31:0] w;
    int oe_n;
    logic [4:0] sel;
    start_read(15'd5, 16'hFFE4);
    read_row(w, oe_n, sel);
    checks++; if (sel !== 5'd4 || w !== grid[4]) begin errors++; $display("FAIL upper_bits got sel=%0d word=%h want sel=4 word=%h", sel, w, grid[4]); end
    end_xfer();
  endtask

  task automatic test_not_selected();
    logic q, oe;
    int oe_n, ones;
    oe_n = 0; ones = 0;
    start_read(15'd6, 16'd10);
    for (int k = 0; k < 40; k++) begin
      host_bit(1'b0, q, oe);
      if (oe) oe_n++;
      if (q !== 1'b0) ones++;
    end
    checks++; if (oe_n !== 0) begin errors++; $display("FAIL unsel_oe got %0d want 0", oe_n); end
    checks++; if (ones !== 0) begin errors++; $display("FAIL unsel_data got %0d ones want 0", ones); end
    checks++; if (row_select !== 5'd11) begin errors++; $display("FAIL unsel_sel got %0d want 11", row_select); end
    end_xfer();
  endtask

  task automatic test_reserved();
    logic q, oe;
    int oe_n;
    logic [31:0] w;
    logic [4:0] sel;
    oe_n = 0;
    dump_if.i_dump_cs = 1'b0;
    #80;
    host_bit(1'b1, q, oe);
    for (int k = 0; k < 80; k++) begin
      host_bit(k[0], q, oe);
      if (oe) oe_n++;
    end
    checks++; if (oe_n !== 0) begin errors++; $display("FAIL reserved_oe got %0d want 0", oe_n); end
    checks++; if (row_select !== 5'd11) begin errors++; $display("FAIL reserved_sel got %0d want 11", row_select); end
    end_xfer();
    start_read(15'd5, 16'd2);
    read_row(w, oe_n, sel);
    checks++; if (w !== grid[2] || sel !== 5'd2 || oe_n !== 32) begin errors++; $display("FAIL after_reserved got %h sel=%0d oe=%0d want %h sel=2 oe=32", w, sel, oe_n, grid[2]); end
    end_xfer();
  endtask

  task automatic test_abort();
    logic q, oe;
    int oe_n;
    logic [31:0] w;
    logic [4:0] sel;
    start_read(15'd5, 16'd9);
    for (int k = 0; k < 10; k++) host_bit(1'b0, q, oe);
    end_xfer();
    start_read(15'd5, 16'd7);
    read_row(w, oe_n, sel);
    checks++; if (w !== grid[7] || sel !== 5'd7) begin errors++; $display("FAIL abort_row7 got %h sel=%0d want %h sel=7", w, sel, grid[7]); end
    read_row(w, oe_n, sel);
    checks++; if (w !== grid[8] || sel !== 5'd8) begin errors++; $display("FAIL abort_row8 got %h sel=%0d want %h sel=8", w, sel, grid[8]); end
    end_xfer();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) grid[i] = {8'(i), 8'(~i), 8'(i * 7 + 3), 8'(i * 13 + 1)};
    grid[3] = 32'hA5A5_0F0F;
    dump_if.i_dump_cs   = 1'b1;
    dump_if.i_dump_clk  = 1'b0;
    dump_if.i_dump_data = 1'b0;
    test_reset();
    test_single_row();
    test_wrap();
    test_upper_row_bits();
    test_not_selected();
    test_reserved();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
